// File: rtl/regfile_pkg.sv
// Shared register-file constants and the write-back queue entry type.
package regfile_pkg;

    localparam int REG_COUNT  = 32;
    localparam int REG_ADDR_W = $clog2(REG_COUNT);
    localparam int REG_DATA_W = 32;

    // One pending register-file write. The destination field is named wreg
    // because "reg" is a reserved word.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] wreg;
        logic [REG_DATA_W-1:0] data;
    } wbq_entry_t;

endpackage

// File: rtl/regfile_wb_queue_match.sv
// wbq_match: finds the youngest valid queue entry whose destination equals a
// read index. Entries are aged from the head pointer, so scanning oldest to
// youngest and letting later hits override leaves the youngest one.
// The data path only exists when REGFILE_WBQ_FWD_EN is defined; without it
// only the hit flag is needed.
module wbq_match
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][REG_ADDR_W-1:0] regs_i,
`ifdef REGFILE_WBQ_FWD_EN
    input  logic [DEPTH-1:0][REG_DATA_W-1:0] datas_i,
    output logic [REG_DATA_W-1:0]            data_o,
`endif
    input  logic [DEPTH-1:0]                 valid_i,
    input  logic [PTR_W-1:0]                 head_i,
    input  logic [REG_ADDR_W-1:0]            idx_i,
    output logic                             hit_o
);

    logic [PTR_W-1:0] slot;

    // Oldest-to-youngest scan; the last match seen is the youngest.
    always_comb begin
        hit_o = 1'b0;
`ifdef REGFILE_WBQ_FWD_EN
        data_o = '0;
`endif
        slot = head_i;
        for (int k = 0; k < DEPTH; k++) begin
            slot = head_i + PTR_W'(k);
            if (valid_i[slot] && (regs_i[slot] == idx_i)) begin
                hit_o = 1'b1;
`ifdef REGFILE_WBQ_FWD_EN
                data_o = datas_i[slot];
`endif
            end
        end
    end

endmodule

// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: FIFO of pending register-file writes between write-back
// and the register file's write port, retiring one entry per unstalled cycle.
// Read data is post-processed so readers see pending writes: forwarded when
// REGFILE_WBQ_FWD_EN is defined, otherwise flagged as a hazard.
module regfile_wb_queue
    import regfile_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W,
    localparam int CNT_W = $clog2(DEPTH) + 1,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              ctrl_reset_n,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              wr_stall,
    output logic              ctrl_writeEnable,
    output logic [ADDR_W-1:0] ctrl_writeReg,
    output logic [DATA_W-1:0] data_writeReg,
    input  logic [ADDR_W-1:0] rd_regA,
    input  logic [ADDR_W-1:0] rd_regB,
    input  logic [DATA_W-1:0] data_readRegA,
    input  logic [DATA_W-1:0] data_readRegB,
    output logic [DATA_W-1:0] rd_dataA,
    output logic [DATA_W-1:0] rd_dataB,
    output logic              rd_hazardA,
    output logic              rd_hazardB,
    output logic [CNT_W-1:0]  wbq_count
);

    // ADDR_W/DATA_W must equal the package widths; entries use the package type.
    wbq_entry_t [DEPTH-1:0] mem_q;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic empty;
    logic push;
    logic pop;

    logic [DEPTH-1:0]                 valid_mask;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_regs;
`ifdef REGFILE_WBQ_FWD_EN
    logic [DEPTH-1:0][REG_DATA_W-1:0] entry_datas;
`endif

    assign empty    = (count_q == '0);
    assign wb_ready = (count_q < CNT_W'(DEPTH));
    // Writes to r0 handshake normally but are dropped here.
    assign push     = wb_valid && wb_ready && (wb_reg != '0);
    assign pop      = !empty && !wr_stall;

    assign ctrl_writeEnable = pop;
    assign ctrl_writeReg    = empty ? '0 : mem_q[head_q].wreg;
    assign data_writeReg    = empty ? '0 : mem_q[head_q].data;
    assign wbq_count        = count_q;

    // Next-state for pointers and occupancy; DEPTH is a power of two so the
    // pointers wrap on their own width.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end
        if (push) begin
            tail_d = tail_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Queue control state; reset discards all pending writes.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents of unoccupied slots are never observed.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[tail_q] <= '{wreg: wb_reg, data: wb_data};
        end
    end

    // Slot gi is occupied when its age relative to the head is below the count.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [PTR_W-1:0] age;
            assign age            = PTR_W'(gi) - head_q;
            assign valid_mask[gi] = (CNT_W'(age) < count_q);
            assign entry_regs[gi] = mem_q[gi].wreg;
`ifdef REGFILE_WBQ_FWD_EN
            assign entry_datas[gi] = mem_q[gi].data;
`endif
        end
    endgenerate

    logic [1:0][ADDR_W-1:0] rd_idx;
    logic [1:0][DATA_W-1:0] rd_raw;
    logic [1:0][DATA_W-1:0] rd_out;
    logic [1:0]             rd_haz;

    assign rd_idx[0] = rd_regA;
    assign rd_idx[1] = rd_regB;
    assign rd_raw[0] = data_readRegA;
    assign rd_raw[1] = data_readRegB;

    // One matcher per read port; r0 always reads 0 without a hazard.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            logic hit;
            logic idx_zero;
            assign idx_zero = (rd_idx[gi] == '0);
`ifdef REGFILE_WBQ_FWD_EN
            logic [REG_DATA_W-1:0] hit_data;
            wbq_match #(.DEPTH(DEPTH)) u_match (
                .regs_i  (entry_regs),
                .datas_i (entry_datas),
                .data_o  (hit_data),
                .valid_i (valid_mask),
                .head_i  (head_q),
                .idx_i   (rd_idx[gi]),
                .hit_o   (hit)
            );
            assign rd_out[gi] = idx_zero ? '0 : (hit ? hit_data : rd_raw[gi]);
            assign rd_haz[gi] = 1'b0;
`else
            wbq_match #(.DEPTH(DEPTH)) u_match (
                .regs_i  (entry_regs),
                .valid_i (valid_mask),
                .head_i  (head_q),
                .idx_i   (rd_idx[gi]),
                .hit_o   (hit)
            );
            assign rd_out[gi] = idx_zero ? '0 : rd_raw[gi];
            assign rd_haz[gi] = !idx_zero && hit;
`endif
        end
    endgenerate

    assign rd_dataA   = rd_out[0];
    assign rd_dataB   = rd_out[1];
    assign rd_hazardA = rd_haz[0];
    assign rd_hazardB = rd_haz[1];

endmodule
